// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {REL, P_WAIT, PRESSED, R_WAIT} db_state_t;

    function automatic longint ms_to_cycles(input longint freq, input longint ms);
        return freq / 1000 * ms;
    endfunction

    // Counter width able to hold the value n; never narrower than one bit.
    function automatic int cnt_width(input longint n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, press/release FSM with stable-window
// counter, and a hold counter that raises a one-shot long-press pulse.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 100,
    parameter int   LONG_CYCLES   = 500,
    parameter int   SYNC_STAGES   = 2,
    parameter logic INV           = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int              CW        = cnt_width(STABLE_CYCLES);
    localparam int              HW        = cnt_width(LONG_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
    localparam bit              LONG_EN   = (LONG_CYCLES > 0);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;

    db_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic          long_done_reg, long_done_next;
    logic          level_reg, level_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic          long_reg, long_next;

    // Reset loads the idle polarity so an idle active-low pin never looks pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= {SYNC_STAGES{INV}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], button};
        end
    end

    assign s = sync_reg[SYNC_STAGES-1] ^ INV;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= REL;
            cnt_reg       <= '0;
            hold_reg      <= '0;
            long_done_reg <= 1'b0;
            level_reg     <= 1'b0;
            press_reg     <= 1'b0;
            release_reg   <= 1'b0;
            long_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hold_reg      <= hold_next;
            long_done_reg <= long_done_next;
            level_reg     <= level_next;
            press_reg     <= press_next;
            release_reg   <= release_next;
            long_reg      <= long_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        hold_next      = hold_reg;
        long_done_next = long_done_reg;
        level_next     = level_reg;
        press_next     = 1'b0;
        release_next   = 1'b0;
        long_next      = 1'b0;

        // Hold keeps counting through R_WAIT so release bounce does not restart it.
        if (LONG_EN && (state_reg == PRESSED || state_reg == R_WAIT) && !long_done_reg) begin
            if (hold_reg == HOLD_LAST) begin
                long_next      = 1'b1;
                long_done_next = 1'b1;
            end else begin
                hold_next = hold_reg + 1'b1;
            end
        end

        case (state_reg)
            REL: begin
                if (s) begin
                    state_next = P_WAIT;
                    cnt_next   = '0;
                end
            end
            P_WAIT: begin
                if (!s) begin
                    state_next = REL;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next     = PRESSED;
                    cnt_next       = '0;
                    level_next     = 1'b1;
                    press_next     = 1'b1;
                    hold_next      = '0;
                    long_done_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = R_WAIT;
                    cnt_next   = '0;
                end
            end
            R_WAIT: begin
                if (s) begin
                    state_next = PRESSED;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = REL;
                    cnt_next     = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = REL;
            end
        endcase
    end

    assign level         = level_reg;
    assign press         = press_reg;
    assign release_pulse = release_reg;
    assign long_press    = long_reg;

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent debounce channels with level, press/release and long-press outputs.
// The release output is named release_pulse because "release" is a reserved word.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int              N_CH           = 4,
    parameter int              CLK_FREQ       = 100_000_000,
    parameter int              STABLE_TIME_MS = 50,
    parameter int              LONG_PRESS_MS  = 1000,
    parameter int              SYNC_STAGES    = 2,
    parameter logic [N_CH-1:0] INVERT         = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press
);

    localparam int STABLE_CYCLES = int'(ms_to_cycles(CLK_FREQ, STABLE_TIME_MS));
    localparam int LONG_CYCLES   = int'(ms_to_cycles(CLK_FREQ, LONG_PRESS_MS));

    if (STABLE_CYCLES < 2 || (LONG_CYCLES != 0 && LONG_CYCLES <= STABLE_CYCLES)
        || SYNC_STAGES < 2) begin : g_bad_cfg
        $error("debounce_multi: invalid timing configuration");
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .INV           (INVERT[gi])
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .button        (button[gi]),
            .level         (level[gi]),
            .press         (press[gi]),
            .release_pulse (release_pulse[gi]),
            .long_press    (long_press[gi])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus queues expected pulses by cycle,
// a negedge monitor matches every observed pulse and flags missing ones.
module tb_debounce_multi;

    localparam int N_CH = 4;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] button = 4'b1000;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_press;

    debounce_multi #(
        .N_CH           (N_CH),
        .CLK_FREQ       (100_000),
        .STABLE_TIME_MS (1),
        .LONG_PRESS_MS  (5),
        .SYNC_STAGES    (2),
        .INVERT         (4'b1000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button        (button),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;
    ev_t exp_q[$];

    function automatic string kname(int k);
        case (k)
            0:       return "press";
            1:       return "release";
            default: return "long_press";
        endcase
    endfunction

    function automatic logic pulse_bit(int k, int ch);
        case (k)
            0:       return press[ch];
            1:       return release_pulse[ch];
            default: return long_press[ch];
        endcase
    endfunction

    task automatic advance(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(int c, int k, int ch);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        exp_q.push_back(e);
    endtask

    // Called #1 after a rising edge; returns the number of the edge that samples it.
    task automatic drive(int ch, logic v, output int e0);
        button[ch] = v;
        e0 = cyc + 1;
    endtask

    task automatic check(string name, logic [N_CH-1:0] act, logic [N_CH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end else begin
            $display("check %s: %b ok", name, act);
        end
    endtask

    // Monitor: every pulse must match a queued expectation for this exact cycle.
    always @(negedge clk) begin
        int idx;
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    if (pulse_bit(k, ch)) begin
                        idx = -1;
                        foreach (exp_q[i]) begin
                            if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].kind == k
                                && exp_q[i].ch == ch) begin
                                idx = i;
                            end
                        end
                        vectors++;
                        if (idx >= 0) begin
                            exp_q.delete(idx);
                            $display("cycle %0d: %s[%0d] ok", cyc, kname(k), ch);
                        end else begin
                            miscompares++;
                            $display("FAIL pulse %s[%0d]: got pulse at cycle %0d, required none",
                                     kname(k), ch, cyc);
                        end
                    end
                end
            end
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pulse %s[%0d]: got none by cycle %0d, required at cycle %0d",
                             kname(exp_q[i].kind), exp_q[i].ch, cyc, exp_q[i].cyc);
                    exp_q.delete(i);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, e1, p;
        int iv[6];
        logic v;
        iv = '{40, 20, 13, 10, 8, 6};

        // Reset state and idle: active-low ch3 idles high and must stay quiet.
        advance(3);
        check("rst_level", level, 4'b0000);
        check("rst_press", press, 4'b0000);
        check("rst_release", release_pulse, 4'b0000);
        check("rst_long", long_press, 4'b0000);
        reset = 1'b0;
        advance(300);
        check("idle_level", level, 4'b0000);
        check("idle_pulses", press | release_pulse | long_press, 4'b0000);

        // Clean step press and release on ch0.
        drive(0, 1'b1, e0);
        expect_ev(e0 + 102, 0, 0);
        advance(150);
        check("step_level_hi", level, 4'b0001);
        drive(0, 1'b0, e1);
        expect_ev(e1 + 102, 1, 0);
        advance(150);
        check("step_level_lo", level, 4'b0000);

        // Bounce on ch1, settling high; one press after the last edge.
        v = 1'b1;
        drive(1, v, e0);
        foreach (iv[i]) begin
            advance(iv[i]);
            v = ~v;
            drive(1, v, e0);
        end
        expect_ev(e0 + 102, 0, 1);
        advance(150);
        check("bounce_level_hi", level, 4'b0010);
        drive(1, 1'b0, e1);
        expect_ev(e1 + 102, 1, 1);
        advance(150);
        check("bounce_level_lo", level, 4'b0000);

        // 99-cycle glitch on ch2: one short of the window, must be rejected.
        drive(2, 1'b1, e0);
        advance(99);
        drive(2, 1'b0, e1);
        advance(150);
        check("glitch_level", level, 4'b0000);

        // Long hold on ch0 with a 50-cycle release bounce 300 cycles after press.
        drive(0, 1'b1, e0);
        p = e0 + 102;
        expect_ev(p, 0, 0);
        expect_ev(p + 500, 2, 0);
        advance(402);
        drive(0, 1'b0, e1);
        advance(50);
        drive(0, 1'b1, e1);
        advance(548);
        check("long_level_hi", level, 4'b0001);
        drive(0, 1'b0, e1);
        expect_ev(e1 + 102, 1, 0);
        advance(150);
        check("long_level_lo", level, 4'b0000);

        // Simultaneous press on ch0 (active-high) and ch3 (active-low).
        button = 4'b0001;
        e0 = cyc + 1;
        expect_ev(e0 + 102, 0, 0);
        expect_ev(e0 + 102, 0, 3);
        advance(150);
        check("simul_level_hi", level, 4'b1001);
        button = 4'b1000;
        e1 = cyc + 1;
        expect_ev(e1 + 102, 1, 0);
        expect_ev(e1 + 102, 1, 3);
        advance(150);
        check("simul_level_lo", level, 4'b0000);

        // Asynchronous reset mid-hold on ch0: level drops at once, no release/long.
        drive(0, 1'b1, e0);
        expect_ev(e0 + 102, 0, 0);
        advance(300);
        check("hold_level", level, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_level", level, 4'b0000);
        check("rst_async_pulses", press | release_pulse | long_press, 4'b0000);
        button[0] = 1'b0;
        advance(5);
        reset = 1'b0;
        advance(700);
        check("post_rst_level", level, 4'b0000);

        advance(10);
        foreach (exp_q[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL pulse %s[%0d]: got none, required at cycle %0d",
                     kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
